// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) behind a start/done handshake.
// Define SERIAL_SUB_SIGNED_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               bor_q, bor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;

    logic               load;
    logic               finish;
    logic               bit_diff;
    logic               bor_next;
    logic [WIDTH-1:0]   res_next;

    // One full-subtractor step on the current LSBs.
    assign bit_diff = sa_q[0] ^ sb_q[0] ^ bor_q;
    assign bor_next = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & bor_q) | (sb_q[0] & bor_q);
    assign res_next = {bit_diff, res_q[WIDTH-1:1]};

    // start is honoured only when no run is in progress.
    assign load   = start && (state_q != RUN);
    assign finish = (state_q == RUN) && (cnt_q == LAST_BIT);

    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        bor_d    = bor_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (load) begin
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = res_next;
                bor_d = bor_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (finish) begin
                    diff_d   = res_next;
                    borrow_d = bor_next;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            bor_q    <= bor_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUB_SIGNED_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Operand MSBs are kept from the capture edge; the result MSB is the final serial bit.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (load) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        if (finish) begin
            ovf_d = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, handshake corner cases
// and a random sweep against {borrow,diff} = {1'b0,a} - {1'b0,b}.
module tb_serial_subtractor;

    localparam int W = 8;
`ifdef SERIAL_SUB_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf_s;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit inject,
                          output int lat, output int busy_cnt);
        int cycles;
        a     = oa;
        b     = ob;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 4 * W) begin
            if (busy) busy_cnt++;
            if (inject && cycles == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        lat   = cycles - 1;
    endtask

    initial begin
        vec_t         vecs[9];
        int           lat;
        int           bcnt;
        int           done_seen;
        logic [W-1:0] ra, rb;
        logic [W:0]   ref_full;
        logic         ref_ovf;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_diff",   32'(diff),   32'd0);
        check("reset_borrow", 32'(borrow), 32'd0);
        check("reset_ovf",    32'(ovf),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
            check($sformatf("vec%0d_latency", i), 32'(lat),    32'(W));
            check($sformatf("vec%0d_busy",    i), 32'(bcnt),   32'(W));
            check($sformatf("vec%0d_diff",    i), 32'(diff),   32'(vecs[i].diff));
            check($sformatf("vec%0d_borrow",  i), 32'(borrow), 32'(vecs[i].borrow));
            check($sformatf("vec%0d_ovf",     i), 32'(ovf),    32'(SIGNED_EN ? vecs[i].ovf_s : 1'b0));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_diff_hold",  i), 32'(diff), 32'(vecs[i].diff));
        end

        // start re-pulsed mid-run must be ignored.
        run_op(8'h05, 8'h03, 1'b1, lat, bcnt);
        check("ignore_latency", 32'(lat),    32'(W));
        check("ignore_busy",    32'(bcnt),   32'(W));
        check("ignore_diff",    32'(diff),   32'h02);
        check("ignore_borrow",  32'(borrow), 32'd0);
        @(negedge clk);
        check("ignore_idle_after", 32'(busy), 32'd0);

        // Reset in cycle 4 of a run aborts it with no done pulse.
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_diff",   32'(diff),   32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_done",   32'(done),   32'd0);
        done_seen = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op(8'h03, 8'h05, 1'b0, lat, bcnt);
        check("after_abort_latency", 32'(lat),    32'(W));
        check("after_abort_diff",    32'(diff),   32'hFE);
        check("after_abort_borrow",  32'(borrow), 32'd1);
        @(negedge clk);

        // Back-to-back: start held in the DONE cycle launches the next run immediately.
        run_op(8'h80, 8'h01, 1'b0, lat, bcnt);
        check("b2b_first_diff", 32'(diff), 32'h7F);
        check("b2b_first_ovf",  32'(ovf),  32'(SIGNED_EN));
        run_op(8'h7F, 8'hFF, 1'b0, lat, bcnt);
        check("b2b_done_spacing", 32'(lat + 1), 32'(W + 1));
        check("b2b_busy",         32'(bcnt),    32'(W));
        check("b2b_second_diff",  32'(diff),    32'h80);
        check("b2b_second_ovf",   32'(ovf),     32'(SIGNED_EN));
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            ra       = W'($urandom);
            rb       = W'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb};
            ref_ovf  = SIGNED_EN && (ra[W-1] != rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            run_op(ra, rb, 1'b0, lat, bcnt);
            check($sformatf("rand%0d_diff %0h-%0h", i, ra, rb), 32'(diff),   32'(ref_full[W-1:0]));
            check($sformatf("rand%0d_borrow",       i),         32'(borrow), 32'(ref_full[W]));
            check($sformatf("rand%0d_ovf",          i),         32'(ovf),    32'(ref_ovf));
            if (i % 2 == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
